instruction_fetch_unit: RTL

- Fetch stage of the RV32IM pipeline: holds the PC, issues word reads to the instruction memory/cache and fills the IF/ID register.
- ID_INSTR[31:7] is the immediate-generation input; the rest of ID_INSTR goes to decode.
- Handles memory wait states, hazard-unit stalls through a one-entry buffer, and branch/jump redirects, including redirects that arrive during an in-flight access.

---
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: owns the PC, issues word reads to instruction memory and fills IF/ID.
// A one-entry buffer absorbs a fetch that completes under a stall; DISCARD drains a redirected in-flight read.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_DATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] ID_INSTR,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic        ID_VALID
);

  typedef enum logic [1:0] {FETCH, BUFFERED, DISCARD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        read_q, read_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic        complete;
  logic [31:0] pc_plus4;

  assign complete = read_q & ~IMEM_BUSYWAIT;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    read_d        = read_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc4_d      = id_pc4_q;
    id_valid_d    = id_valid_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    redirect_pc_d = redirect_pc_q;

    if (BRANCH_TAKEN) begin
      id_instr_d = NOP_INSTR;
      id_valid_d = 1'b0;
      // An in-flight busy read must finish at its own address before the PC may move.
      if (!IMEM_BUSYWAIT || !read_q) begin
        pc_d    = {BRANCH_TARGET[31:2], 2'b00};
        read_d  = 1'b1;
        state_d = FETCH;
      end else begin
        redirect_pc_d = {BRANCH_TARGET[31:2], 2'b00};
        state_d       = DISCARD;
      end
    end else begin
      case (state_q)
        FETCH: begin
          read_d = 1'b1;
          if (complete) begin
            pc_d = pc_plus4;
            if (STALL) begin
              buf_instr_d = IMEM_DATA;
              buf_pc_d    = pc_q;
              read_d      = 1'b0;
              state_d     = BUFFERED;
            end else begin
              id_instr_d = IMEM_DATA;
              id_pc_d    = pc_q;
              id_pc4_d   = pc_plus4;
              id_valid_d = 1'b1;
            end
          end else if (!STALL) begin
            id_valid_d = 1'b0;
          end
        end
        BUFFERED: begin
          if (!STALL) begin
            id_instr_d = buf_instr_q;
            id_pc_d    = buf_pc_q;
            id_pc4_d   = buf_pc_q + 32'd4;
            id_valid_d = 1'b1;
            read_d     = 1'b1;
            state_d    = FETCH;
          end
        end
        DISCARD: begin
          if (complete) begin
            pc_d    = redirect_pc_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      read_q        <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc4_q      <= 32'd0;
      id_valid_q    <= 1'b0;
      buf_instr_q   <= NOP_INSTR;
      buf_pc_q      <= 32'd0;
      redirect_pc_q <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      read_q        <= read_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc4_q      <= id_pc4_d;
      id_valid_q    <= id_valid_d;
      buf_instr_q   <= buf_instr_d;
      buf_pc_q      <= buf_pc_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign IMEM_ADDR = pc_q;
  assign IMEM_READ = read_q;
  assign ID_INSTR  = id_instr_q;
  assign ID_PC     = id_pc_q;
  assign ID_PC4    = id_pc4_q;
  assign ID_VALID  = id_valid_q;

endmodule
